// File: rtl/sync_fifo_fwft_if.sv
// Stream handshake bundle for sync_fifo_fwft: one write side and one read side.
//
// Handshake rule for both sides: a word moves on a rising edge where valid and
// ready are both high. The source holds valid and data steady until that edge,
// and valid never waits on ready. The sink may raise or lower ready freely.
interface sync_fifo_fwft_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Producer/consumer side: drives writes and accepts reads.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // FIFO side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy flags, synchronous
// flush and a high-water-mark monitor. The head word is read straight out of
// the storage array, so a word written at one edge is visible the next cycle.
module sync_fifo_fwft #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    sync_fifo_fwft_if.slave      bus,
    output logic [CW-1:0]        count,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [CW-1:0]        hwm,
    input  logic                 hwm_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);

    // Pointer wrap relies on DEPTH being a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_fwft: DEPTH must be a power of two and at least 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
        $error("sync_fifo_fwft: AFULL_THRESH must be within 1..DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH >= DEPTH)) begin : g_bad_aempty
        $error("sync_fifo_fwft: AEMPTY_THRESH must be within 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    hwm_q;
    logic [CW-1:0]    hwm_next;
    logic             wr_fire;
    logic             rd_fire;

    // Ready/valid come only from the stored occupancy: no write-through when
    // full and no bypass when empty, which keeps both sides free of
    // combinational paths into each other.
    assign bus.in_ready  = (count_q != FULL_CNT);
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem[rd_ptr];

    assign wr_fire = bus.in_valid & bus.in_ready;
    assign rd_fire = bus.out_valid & bus.out_ready;

    assign count        = count_q;
    assign hwm          = hwm_q;
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);

    // Next occupancy; flush discards any handshake presented in its cycle.
    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   count_next = count_q + 1'b1;
                2'b01:   count_next = count_q - 1'b1;
                default: count_next = count_q;
            endcase
        end
    end

    // High-water mark follows the next occupancy; a clear restarts tracking
    // from that occupancy rather than from zero.
    always_comb begin
        hwm_next = hwm_q;
        if (hwm_clr) begin
            hwm_next = count_next;
        end else if (count_next > hwm_q) begin
            hwm_next = count_next;
        end
    end

    // Pointer, occupancy and high-water-mark registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            hwm_q   <= '0;
        end else begin
            hwm_q <= hwm_next;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                count_q <= count_next;
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_fire && !flush && !rst) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

endmodule
